// File: rtl/mycpu_pkg.sv
// Shared types for the mycpu function unit: opcode encoding, pipe states and
// the signed saturation helper used by the arithmetic and multiply paths.
package mycpu_pkg;

  typedef enum logic [3:0] {
    FMOVA = 4'd0,
    FINC  = 4'd1,
    FADD  = 4'd2,
    FSUB  = 4'd3,
    FDEC  = 4'd4,
    FMUL  = 4'd5,
    FSRA  = 4'd6,
    FSLA  = 4'd7,
    FSHR  = 4'd8,
    FSHL  = 4'd9,
    FAND  = 4'd10,
    FOR   = 4'd11,
    FXOR  = 4'd12,
    FNOT  = 4'd13,
    FMOVB = 4'd14,
    FCLR  = 4'd15
  } fs_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } fu_state_t;

  // Wide enough for a signed 2*32-bit product plus sign and headroom.
  localparam int unsigned SAT_W = 66;

  function automatic logic signed [SAT_W-1:0] sat_clip(
    input logic signed [SAT_W-1:0] value,
    input int unsigned             width
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (width - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/fu_mul_iter.sv
// Iterative shift-add magnitude multiplier: one partial product per enabled
// cycle, DATA_W cycles after start; o_done_c holds until the next start.
module fu_mul_iter #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_en,
  input  logic [DATA_W-1:0]     i_a_mag,
  input  logic [DATA_W-1:0]     i_b_mag,
  output logic                  o_done_c,
  output logic [2*DATA_W-1:0]   o_prod
);

  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [PROD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_last;

  assign w_last   = (r_cnt == CNT_W'(DATA_W));
  assign o_done_c = i_en && w_last;
  assign o_prod   = r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= PROD_W'(i_a_mag);
      r_mplier <= i_b_mag;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_en && !w_last) begin
      r_acc    <= r_mplier[0] ? (r_acc + r_mcand) : r_acc;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fu_pipe.sv
// Handshaked function unit: single-cycle ALU ops, iterative saturating FMUL.
// Define MYCPU_FU_SATARITH_EN to saturate FINC/FADD/FSUB/FDEC instead of wrapping.
module fu_pipe
  import mycpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [3:0]        fs_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] f_out,
  output logic              z_out,
  output logic              n_out,
  output logic              v_out,
  output logic [3:0]        fs_out,
  output logic              busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  fu_state_t         r_state;
  fu_state_t         w_state_nxt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_f;
  logic              r_z;
  logic              r_n;
  logic              r_v;
  logic [3:0]        r_fs;
  logic              r_busy;
  logic              r_mul_neg;

  fs_t               w_op;
  logic              w_out_free;
  logic              w_accept;
  logic              w_mul_start;
  logic              w_mul_en;
  logic              w_mul_done;
  logic              w_load;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic [PROD_W-1:0] w_prod;

  logic signed [SAT_W-1:0] w_a_s;
  logic signed [SAT_W-1:0] w_b_s;
  logic signed [SAT_W-1:0] w_arith;
  logic signed [SAT_W-1:0] w_arith_clip;
  logic signed [SAT_W-1:0] w_mul_s;
  logic signed [SAT_W-1:0] w_mul_clip;
  logic              w_is_arith;
  logic [DATA_W-1:0] w_logic_f;
  logic [DATA_W-1:0] w_arith_f;
  logic [DATA_W-1:0] w_alu_f;
  logic              w_alu_v;
  logic [DATA_W-1:0] w_f_nxt;
  logic              w_v_nxt;
  logic [3:0]        w_fs_nxt;

  assign w_op        = fs_t'(fs_in);
  assign w_out_free  = !r_out_valid || out_ready;
  assign in_ready    = (r_state == S_IDLE) && w_out_free;
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (w_op == FMUL);
  assign w_mul_en    = (r_state == S_MUL);
  // Two's-complement magnitude; the most negative value maps to 2^(W-1) unsigned.
  assign w_a_mag     = a_in[DATA_W-1] ? -a_in : a_in;
  assign w_b_mag     = b_in[DATA_W-1] ? -b_in : b_in;

  fu_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_mul_start),
    .i_en     (w_mul_en),
    .i_a_mag  (w_a_mag),
    .i_b_mag  (w_b_mag),
    .o_done_c (w_mul_done),
    .o_prod   (w_prod)
  );

  // Single-cycle datapath; arithmetic is evaluated wide so overflow is a range check.
  always_comb begin
    w_a_s      = SAT_W'(signed'(a_in));
    w_b_s      = SAT_W'(signed'(b_in));
    w_arith    = '0;
    w_is_arith = 1'b0;
    w_logic_f  = '0;
    case (w_op)
      FINC:  begin w_arith = w_a_s + SAT_W'(1); w_is_arith = 1'b1; end
      FADD:  begin w_arith = w_a_s + w_b_s;     w_is_arith = 1'b1; end
      FSUB:  begin w_arith = w_a_s - w_b_s;     w_is_arith = 1'b1; end
      FDEC:  begin w_arith = w_a_s - SAT_W'(1); w_is_arith = 1'b1; end
      FMOVA: w_logic_f = a_in;
      FSRA:  w_logic_f = {b_in[DATA_W-1], b_in[DATA_W-1:1]};
      FSLA,
      FSHL:  w_logic_f = {b_in[DATA_W-2:0], 1'b0};
      FSHR:  w_logic_f = {1'b0, b_in[DATA_W-1:1]};
      FAND:  w_logic_f = a_in & b_in;
      FOR:   w_logic_f = a_in | b_in;
      FXOR:  w_logic_f = a_in ^ b_in;
      FNOT:  w_logic_f = ~a_in;
      FMOVB: w_logic_f = b_in;
      default: w_logic_f = '0;
    endcase
    w_arith_clip = sat_clip(w_arith, DATA_W);
    w_alu_v      = w_is_arith && (w_arith_clip != w_arith);
`ifdef MYCPU_FU_SATARITH_EN
    w_arith_f    = w_arith_clip[DATA_W-1:0];
`else
    w_arith_f    = w_arith[DATA_W-1:0];
`endif
    w_alu_f      = w_is_arith ? w_arith_f : w_logic_f;
  end

  always_comb begin
    w_mul_s = SAT_W'(w_prod);
    if (r_mul_neg) w_mul_s = -w_mul_s;
    w_mul_clip = sat_clip(w_mul_s, DATA_W);
  end

  // Next state / output-register load; a finished multiply waits if the slot is full.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_f_nxt     = w_alu_f;
    w_v_nxt     = w_alu_v;
    w_fs_nxt    = fs_in;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_op == FMUL) w_state_nxt = S_MUL;
          else              w_load      = 1'b1;
        end
      end
      S_MUL: begin
        if (w_mul_done && w_out_free) begin
          w_state_nxt = S_IDLE;
          w_load      = 1'b1;
          w_f_nxt     = w_mul_clip[DATA_W-1:0];
          w_v_nxt     = (w_mul_clip != w_mul_s);
          w_fs_nxt    = FMUL;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_f         <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_v         <= 1'b0;
      r_fs        <= '0;
      r_busy      <= 1'b0;
      r_mul_neg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_MUL);
      if (w_mul_start) r_mul_neg <= a_in[DATA_W-1] ^ b_in[DATA_W-1];
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_f         <= w_f_nxt;
        r_z         <= (w_f_nxt == '0);
        r_n         <= w_f_nxt[DATA_W-1];
        r_v         <= w_v_nxt;
        r_fs        <= w_fs_nxt;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign f_out     = r_f;
  assign z_out     = r_z;
  assign n_out     = r_n;
  assign v_out     = r_v;
  assign fs_out    = r_fs;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fu_pipe.sv
// Bench for fu_pipe: integer reference model + in-order scoreboard, directed
// vectors with literal expectations, and a randomized handshake run.
module tb_fu_pipe;
  import mycpu_pkg::*;

  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [3:0]        fs;
    logic              v;
    logic              n;
    logic              z;
    logic [DATA_W-1:0] f;
  } res_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [3:0]        fs_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] f_out;
  logic              z_out;
  logic              n_out;
  logic              v_out;
  logic [3:0]        fs_out;
  logic              busy;

  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  res_t exp_q[$];

  fu_pipe #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .fs_in     (fs_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f_out     (f_out),
    .z_out     (z_out),
    .n_out     (n_out),
    .v_out     (v_out),
    .fs_out    (fs_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain signed integer arithmetic with explicit range clamping.
  function automatic res_t model(input logic [3:0] fs, input logic [DATA_W-1:0] a,
                                 input logic [DATA_W-1:0] b);
    res_t   r;
    longint sa, sb, x, hi, lo;
    logic   ovf;
    sa = $signed(a);
    sb = $signed(b);
    hi = (longint'(1) <<< (DATA_W - 1)) - 1;
    lo = -hi - 1;
    x  = 0;
    r  = '0;
    case (fs)
      FMOVA: r.f = a;
      FINC:  x = sa + 1;
      FADD:  x = sa + sb;
      FSUB:  x = sa - sb;
      FDEC:  x = sa - 1;
      FMUL:  x = sa * sb;
      FSRA:  r.f = DATA_W'(sb >>> 1);
      FSLA:  r.f = b << 1;
      FSHR:  r.f = b >> 1;
      FSHL:  r.f = b << 1;
      FAND:  r.f = a & b;
      FOR:   r.f = a | b;
      FXOR:  r.f = a ^ b;
      FNOT:  r.f = ~a;
      FMOVB: r.f = b;
      default: r.f = '0;
    endcase
    if (fs inside {FINC, FADD, FSUB, FDEC, FMUL}) begin
      ovf = (x > hi) || (x < lo);
      r.v = ovf;
`ifdef MYCPU_FU_SATARITH_EN
      r.f = DATA_W'((x > hi) ? hi : ((x < lo) ? lo : x));
`else
      if (fs == FMUL) r.f = DATA_W'((x > hi) ? hi : ((x < lo) ? lo : x));
      else            r.f = DATA_W'(x);
`endif
    end
    r.z  = (r.f == '0);
    r.n  = r.f[DATA_W-1];
    r.fs = fs;
    return r;
  endfunction

  // Scoreboard: every presented result must equal the oldest outstanding accept.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        check("sb_no_dup", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("sb_result", 32'({fs_out, v_out, n_out, z_out, f_out}), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(fs_in, a_in, b_in));
        n_acc++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [3:0] fs, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    bit acc;
    acc      = 1'b0;
    fs_in    = fs;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("issue_accept", 32'(acc), 32'd1);
  endtask

  task automatic mul_latency(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input logic [DATA_W-1:0] ef, input logic ev, input logic en);
    issue(FMUL, a, b);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      check("mul_busy", 32'(busy), 32'(k <= 16));
      check("mul_valid", 32'(out_valid), 32'(k == 17));
      if (k == 17) begin
        check("mul_f", 32'(f_out), 32'(ef));
        check("mul_v", 32'(v_out), 32'(ev));
        check("mul_n", 32'(n_out), 32'(en));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(output logic [DATA_W-1:0] f, output logic z, output logic v);
    bit seen;
    seen = 1'b0;
    f = '0; z = 1'b0; v = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1; f = f_out; z = z_out; v = v_out;
      end
    end
    check("result_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_val();
    logic [DATA_W-1:0] c;
    case ($urandom % 8)
      0: c = '0;
      1: c = {1'b0, {(DATA_W-1){1'b1}}};
      2: c = {1'b1, {(DATA_W-1){1'b0}}};
      3: c = '1;
      default: c = DATA_W'($urandom);
    endcase
    return c;
  endfunction

  initial begin
    res_t              m;
    logic [DATA_W-1:0] f;
    logic              z, v;
    int                base;
    bit                drained;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; fs_in = '0;

    // Pin the model itself with hand-computed values.
    m = model(FMUL, 16'h0003, 16'h2AAB); check("model_mul_pos", 32'({m.f, m.v}), 32'h0FFFF);
    m = model(FMUL, 16'h0003, 16'hD555); check("model_mul_neg", 32'({m.f, m.v}), 32'h10001);
    m = model(FSRA, 16'h0000, 16'hFFFE); check("model_sra", 32'(m.f), 32'hFFFF);
    m = model(FSUB, 16'h8000, 16'h8000); check("model_sub", 32'({m.f, m.z, m.v}), 32'h2);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_regs", 32'({f_out, z_out, n_out, v_out, fs_out}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    mul_latency(16'h0003, 16'h2AAB, 16'h7FFF, 1'b1, 1'b0);
    mul_latency(16'h0003, 16'hD555, 16'h8000, 1'b1, 1'b1);

    issue(FADD, 16'h7FFF, 16'h0002);
    wait_result(f, z, v);
`ifdef MYCPU_FU_SATARITH_EN
    check("fadd_ovf_f", 32'(f), 32'h7FFF);
`else
    check("fadd_ovf_f", 32'(f), 32'h8001);
`endif
    check("fadd_ovf_v", 32'(v), 32'd1);

    issue(FSUB, 16'h8000, 16'h8000);
    wait_result(f, z, v);
    check("fsub_f", 32'(f), 32'h0);
    check("fsub_zv", 32'({z, v}), 32'h2);

    // Back-to-back single-cycle ops, one result per cycle.
    fs_in = FMOVA; a_in = 16'h0000; b_in = 16'h1111; in_valid = 1'b1;
    @(negedge clk); check("b2b_rdy0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    fs_in = FINC; a_in = 16'hFFFF;
    @(negedge clk);
    check("b2b_rdy1", 32'(in_ready), 32'd1);
    check("b2b_r0", 32'({out_valid, z_out, f_out}), 32'h30000);
    @(posedge clk); #1;
    fs_in = FSRA; b_in = 16'hFFFE;
    @(negedge clk);
    check("b2b_rdy2", 32'(in_ready), 32'd1);
    check("b2b_r1", 32'({out_valid, z_out, f_out}), 32'h30000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_r2", 32'({out_valid, n_out, f_out}), 32'h3FFFF);
    @(posedge clk); #1;

    // Backpressure holds the result and blocks new work.
    out_ready = 1'b0;
    issue(FXOR, 16'h55FF, 16'h00AA);
    fs_in = FMOVB; a_in = 16'h0000; b_in = 16'h1234; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold", 32'({out_valid, f_out}), 32'h15555);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next", 32'({out_valid, f_out}), 32'h11234);
    @(posedge clk); #1;

    // Reset after the 8th multiply iteration discards the multiply.
    issue(FMUL, 16'h0005, 16'h0007);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'({out_valid, busy, in_ready}), 32'b001);
    @(posedge clk); #1;
    mul_latency(16'h0002, 16'h0003, 16'h0006, 1'b0, 1'b0);

    // Random ops with random valid/ready.
    base = n_acc;
    for (int cyc = 0; cyc < 40000 && n_acc < base + 1000; cyc++) begin
      out_ready = ($urandom % 4) != 0;
      in_valid  = ($urandom % 3) != 0;
      fs_in     = 4'($urandom);
      a_in      = rnd_val();
      b_in      = rnd_val();
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_accepts", 32'(n_acc >= base + 1000), 32'd1);
    drained = 1'b0;
    for (int n = 0; n < 100 && !drained; n++) begin
      @(negedge clk);
      drained = (exp_q.size() == 0) && !out_valid && !busy;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
